// File: rtl/y86_fetch_unit.sv
// y86_fetch_unit: Y86-64 fetch front end: aligned word reads, byte extraction, length decode.
// Optional macro Y86_FETCH_LEN_EN: decode length from word 0 and read/range-check only the bytes used.
module y86_fetch_unit #(
  parameter longint unsigned IMEM_BYTES = 64'd65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_pc,
  output logic        req_ready,
  output logic        mem_rd_en,
  output logic [63:0] mem_addr,
  input  logic        mem_rd_valid,
  input  logic [63:0] mem_rd_data,
  input  logic        mem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [79:0] instr,
  output logic [3:0]  instr_len,
  output logic        instr_invalid,
  output logic        imem_error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [64:0] LIMIT = 65'(IMEM_BYTES);

  logic [1:0]       state;
  logic [63:0]      pc;
  logic [1:0]       k;
  logic [1:0]       nwords;
  logic [2:0][63:0] slots;

  logic [2:0][63:0] slots_next;
  logic [79:0]      window;
  logic [79:0]      assembled;
  logic [3:0]       icode;
  logic [3:0]       len_dec;
  logic [1:0]       nwords_acc;
  logic [1:0]       nwords_eff;
  logic             oob_acc;
  logic             oob_mid;
  logic             more;

  assign req_ready = (state == S_IDLE);
  assign mem_rd_en = (state == S_REQ);
  assign mem_addr  = (state == S_REQ) ? ({pc[63:3], 3'b000} + {59'd0, k, 3'b000}) : '0;

  // Accept-time word count and range check (sum widened to 65 bits so wrap counts as out of range).
  always_comb begin
    nwords_acc = 2'(({2'b00, req_pc[2:0]} + 5'd9) >> 3) + 2'd1;
`ifdef Y86_FETCH_LEN_EN
    oob_acc = ({1'b0, req_pc} >= LIMIT);
`else
    oob_acc = (({1'b0, req_pc} + 65'd9) >= LIMIT);
`endif
  end

  // Slot buffer including the word arriving this cycle, so DONE outputs can be registered on entry.
  always_comb begin
    slots_next = slots;
    if (state == S_WAIT) begin
      slots_next[k] = mem_rd_data;
    end
    window = 80'(slots_next >> {pc[2:0], 3'b000});
    icode  = window[7:4];
  end

  always_comb begin
    case (icode)
      4'h0, 4'h1, 4'h9:       len_dec = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len_dec = 4'd2;
      4'h3, 4'h4, 4'h5:       len_dec = 4'd10;
      4'h7, 4'h8:             len_dec = 4'd9;
      default:                len_dec = 4'd1;
    endcase
  end

  always_comb begin
    assembled = '0;
    for (int unsigned i = 0; i < 10; i++) begin
`ifdef Y86_FETCH_LEN_EN
      if (i < 32'(len_dec)) begin
        assembled[79-8*i -: 8] = window[8*i +: 8];
      end
`else
      assembled[79-8*i -: 8] = window[8*i +: 8];
`endif
    end
  end

  // With length decode, word 0 fixes the real word count and the end-of-instruction range check.
  always_comb begin
    nwords_eff = nwords;
    oob_mid    = 1'b0;
`ifdef Y86_FETCH_LEN_EN
    if (k == 2'd0) begin
      nwords_eff = 2'(({2'b00, pc[2:0]} + {1'b0, len_dec} - 5'd1) >> 3) + 2'd1;
      oob_mid    = (({1'b0, pc} + 65'(len_dec) - 65'd1) >= LIMIT);
    end
`endif
    more = (({1'b0, k} + 3'd1) < {1'b0, nwords_eff});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      pc            <= '0;
      k             <= '0;
      nwords        <= '0;
      slots         <= '0;
      out_valid     <= 1'b0;
      instr         <= '0;
      instr_len     <= '0;
      instr_invalid <= 1'b0;
      imem_error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            pc     <= req_pc;
            k      <= '0;
            nwords <= nwords_acc;
            slots  <= '0;
            if (oob_acc) begin
              state         <= S_DONE;
              out_valid     <= 1'b1;
              imem_error    <= 1'b1;
              instr         <= '0;
              instr_len     <= '0;
              instr_invalid <= 1'b0;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rd_valid) begin
            slots  <= slots_next;
            nwords <= nwords_eff;
            if (mem_err || oob_mid) begin
              state         <= S_DONE;
              out_valid     <= 1'b1;
              imem_error    <= 1'b1;
              instr         <= '0;
              instr_len     <= '0;
              instr_invalid <= 1'b0;
            end else if (more) begin
              k     <= k + 2'd1;
              state <= S_REQ;
            end else begin
              state         <= S_DONE;
              out_valid     <= 1'b1;
              imem_error    <= 1'b0;
              instr         <= assembled;
              instr_len     <= len_dec;
              instr_invalid <= (icode > 4'hB);
            end
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Directed self-checking bench for y86_fetch_unit with a 1-cycle-latency byte memory model.
module tb_y86_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [63:0] req_pc = '0;
  logic        req_ready;
  logic        mem_rd_en;
  logic [63:0] mem_addr;
  logic        mem_rd_valid = 1'b0;
  logic [63:0] mem_rd_data = '0;
  logic        mem_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [79:0] instr;
  logic [3:0]  instr_len;
  logic        instr_invalid;
  logic        imem_error;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic        pend = 1'b0;
  logic [63:0] pend_addr = '0;
  logic        mem_hold = 1'b0;
  logic        inject = 1'b0;
  logic        err_en = 1'b0;
  logic [63:0] err_addr = '0;
  int          strobes = 0;
  logic [63:0] addr_q[$];

  y86_fetch_unit #(.IMEM_BYTES(64'd65536)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_err(mem_err), .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .instr_len(instr_len), .instr_invalid(instr_invalid), .imem_error(imem_error)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] word_at(input logic [63:0] a);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = mem[int'(a[15:0]) + j];
    return w;
  endfunction

  // Memory model: a strobe seen in cycle n is answered in cycle n+1.
  always @(negedge clock) begin
    mem_rd_valid = 1'b0;
    mem_err = 1'b0;
    if (reset) pend = 1'b0;
    if (pend) begin
      mem_rd_valid = 1'b1;
      mem_rd_data = word_at(pend_addr);
      mem_err = err_en && (pend_addr == err_addr);
    end else if (inject) begin
      mem_rd_valid = 1'b1;
      mem_rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    pend = 1'b0;
    if (mem_rd_en) begin
      strobes++;
      addr_q.push_back(mem_addr);
      if (!mem_hold) begin
        pend = 1'b1;
        pend_addr = mem_addr;
      end
    end
  end

  task automatic run_fetch(input logic [63:0] pc, output int lat);
    strobes = 0;
    addr_q.delete();
    @(negedge clock);
    req_valid = 1'b1;
    req_pc = pc;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!out_valid && lat < 40);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL fetch_timeout pc=%h: out_valid=%b after %0d cycles, required 1", pc, out_valid, lat);
    end
  endtask

  task automatic release_out();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  task automatic clear_low();
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_mem_rd_en: got %b required 0", mem_rd_en); end
    checks++; if (mem_addr !== 64'd0) begin failures++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (instr !== 80'd0) begin failures++; $display("FAIL reset_instr: got %h required 0", instr); end
    checks++; if (instr_len !== 4'd0) begin failures++; $display("FAIL reset_instr_len: got %0d required 0", instr_len); end
    checks++; if (instr_invalid !== 1'b0 || imem_error !== 1'b0) begin failures++;
      $display("FAIL reset_flags: got invalid=%b err=%b required 0 0", instr_invalid, imem_error); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_aligned();
    int lat;
    clear_low();
    {mem[0], mem[1], mem[2]} = {8'h30, 8'hF2, 8'h0A};
    run_fetch(64'd0, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL aligned_latency: got %0d required 5", lat); end
    checks++; if (strobes != 2 || addr_q.size() != 2 || addr_q[0] !== 64'h0 || addr_q[1] !== 64'h8) begin failures++;
      $display("FAIL aligned_reads: got %0d strobes required 2 at 0x0,0x8", strobes); end
    checks++; if (instr !== 80'h30F2_0A00_0000_0000_0000) begin failures++;
      $display("FAIL aligned_instr: got %h required 30f20a00000000000000", instr); end
    checks++; if (instr_len !== 4'd10 || instr_invalid !== 1'b0 || imem_error !== 1'b0) begin failures++;
      $display("FAIL aligned_len: got len=%0d inv=%b err=%b required 10 0 0", instr_len, instr_invalid, imem_error); end
    release_out();
  endtask

  task automatic test_unaligned();
    int lat;
    clear_low();
    {mem[7], mem[8], mem[9]} = {8'h30, 8'hF2, 8'h0A};
    run_fetch(64'd7, lat);
    checks++; if (lat != 7) begin failures++; $display("FAIL unaligned_latency: got %0d required 7", lat); end
    checks++; if (strobes != 3 || addr_q.size() != 3 || addr_q[0] !== 64'h0 || addr_q[1] !== 64'h8 || addr_q[2] !== 64'h10) begin
      failures++; $display("FAIL unaligned_reads: got %0d strobes required 3 at 0x0,0x8,0x10", strobes); end
    checks++; if (instr !== 80'h30F2_0A00_0000_0000_0000 || instr_len !== 4'd10) begin failures++;
      $display("FAIL unaligned_instr: got %h len=%0d required 30f20a00000000000000 len=10", instr, instr_len); end
    release_out();
  endtask

  task automatic test_short_and_invalid();
    int lat;
    clear_low();
    {mem[8'h41], mem[8'h42]} = {8'h20, 8'h12};
    run_fetch(64'h41, lat);
    checks++; if (instr !== 80'h2012_0000_0000_0000_0000 || instr_len !== 4'd2 || instr_invalid !== 1'b0) begin failures++;
      $display("FAIL rrmovq: got %h len=%0d inv=%b required 20120000000000000000 2 0", instr, instr_len, instr_invalid); end
    release_out();
    {mem[8'h20], mem[8'h21]} = {8'hC0, 8'hAB};
    run_fetch(64'h20, lat);
`ifdef Y86_FETCH_LEN_EN
    checks++; if (instr !== 80'hC000_0000_0000_0000_0000 || strobes != 1) begin failures++;
      $display("FAIL invalid_instr: got %h strobes=%0d required c0000000000000000000 1", instr, strobes); end
`else
    checks++; if (instr !== 80'hC0AB_0000_0000_0000_0000 || strobes != 2) begin failures++;
      $display("FAIL invalid_instr: got %h strobes=%0d required c0ab0000000000000000 2", instr, strobes); end
`endif
    checks++; if (instr_invalid !== 1'b1 || instr_len !== 4'd1 || imem_error !== 1'b0) begin failures++;
      $display("FAIL invalid_flags: got inv=%b len=%0d err=%b required 1 1 0", instr_invalid, instr_len, imem_error); end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    logic stable_ok;
    clear_low();
    {mem[0], mem[1], mem[2]} = {8'h30, 8'hF2, 8'h0A};
    run_fetch(64'd0, lat);
    stable_ok = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (instr !== 80'h30F2_0A00_0000_0000_0000 || out_valid !== 1'b1 || req_ready !== 1'b0) stable_ok = 1'b0;
    end
    checks++; if (stable_ok !== 1'b1) begin failures++;
      $display("FAIL backpressure_hold: got instr=%h valid=%b ready=%b required stable, 1, 0", instr, out_valid, req_ready); end
    release_out();
    checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin failures++;
      $display("FAIL backpressure_release: got valid=%b ready=%b required 0 1", out_valid, req_ready); end
  endtask

  task automatic test_range();
    int lat;
    mem[65526] = 8'h10;
    run_fetch(64'd65526, lat);
`ifdef Y86_FETCH_LEN_EN
    checks++; if (strobes != 1 || lat != 3) begin failures++; $display("FAIL range_edge_reads: got %0d strobes lat=%0d required 1 3", strobes, lat); end
`else
    checks++; if (strobes != 2 || lat != 5) begin failures++; $display("FAIL range_edge_reads: got %0d strobes lat=%0d required 2 5", strobes, lat); end
`endif
    checks++; if (instr !== 80'h1000_0000_0000_0000_0000 || instr_len !== 4'd1 || imem_error !== 1'b0) begin failures++;
      $display("FAIL range_edge: got %h len=%0d err=%b required 10000000000000000000 1 0", instr, instr_len, imem_error); end
    release_out();
    mem[65530] = 8'h00;
    run_fetch(64'd65530, lat);
`ifdef Y86_FETCH_LEN_EN
    checks++; if (strobes != 1 || imem_error !== 1'b0 || instr_len !== 4'd1 || instr !== 80'd0) begin failures++;
      $display("FAIL range_halt: got strobes=%0d err=%b len=%0d instr=%h required 1 0 1 0", strobes, imem_error, instr_len, instr); end
`else
    checks++; if (strobes != 0 || imem_error !== 1'b1 || instr !== 80'd0 || lat != 1) begin failures++;
      $display("FAIL range_halt: got strobes=%0d err=%b instr=%h lat=%0d required 0 1 0 1", strobes, imem_error, instr, lat); end
`endif
    release_out();
    mem[65530] = 8'h30;
    run_fetch(64'd65530, lat);
`ifdef Y86_FETCH_LEN_EN
    checks++; if (strobes != 1 || imem_error !== 1'b1 || instr !== 80'd0) begin failures++;
      $display("FAIL range_irmovq: got strobes=%0d err=%b instr=%h required 1 1 0", strobes, imem_error, instr); end
`else
    checks++; if (strobes != 0 || imem_error !== 1'b1 || instr !== 80'd0) begin failures++;
      $display("FAIL range_irmovq: got strobes=%0d err=%b instr=%h required 0 1 0", strobes, imem_error, instr); end
`endif
    release_out();
    run_fetch(64'hFFFF_FFFF_FFFF_FFFA, lat);
    checks++; if (strobes != 0 || imem_error !== 1'b1 || instr !== 80'd0 || instr_len !== 4'd0) begin failures++;
      $display("FAIL range_wrap: got strobes=%0d err=%b instr=%h len=%0d required 0 1 0 0", strobes, imem_error, instr, instr_len); end
    release_out();
  endtask

  task automatic test_fault();
    int lat;
    clear_low();
    {mem[0], mem[1], mem[2]} = {8'h30, 8'hF2, 8'h0A};
    err_en = 1'b1;
    err_addr = 64'h8;
    run_fetch(64'd0, lat);
    err_en = 1'b0;
    checks++; if (strobes != 2 || imem_error !== 1'b1 || instr !== 80'd0) begin failures++;
      $display("FAIL fault: got strobes=%0d err=%b instr=%h required 2 1 0", strobes, imem_error, instr); end
    checks++; if (instr_len !== 4'd0 || instr_invalid !== 1'b0) begin failures++;
      $display("FAIL fault_len: got len=%0d inv=%b required 0 0", instr_len, instr_invalid); end
    release_out();
  endtask

  task automatic test_reset_in_wait();
    int lat;
    logic quiet;
    mem_hold = 1'b1;
    @(negedge clock);
    req_valid = 1'b1;
    req_pc = 64'd0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_wait_async: got ready=%b rd_en=%b valid=%b required 1 0 0", req_ready, mem_rd_en, out_valid); end
    @(negedge clock);
    reset = 1'b0;
    mem_hold = 1'b0;
    #2 inject = 1'b1;
    @(negedge clock);
    #2 inject = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (out_valid !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin failures++;
      $display("FAIL reset_wait_late_data: got valid=%b ready=%b required 0 1", out_valid, req_ready); end
    run_fetch(64'd0, lat);
    checks++; if (instr !== 80'h30F2_0A00_0000_0000_0000 || instr_len !== 4'd10 || imem_error !== 1'b0 || lat != 5) begin failures++;
      $display("FAIL reset_wait_next: got %h len=%0d err=%b lat=%0d required 30f20a00000000000000 10 0 5", instr, instr_len, imem_error, lat); end
    release_out();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_aligned();
    test_unaligned();
    test_short_and_invalid();
    test_backpressure();
    test_range();
    test_fault();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
